// File: rtl/fpu_mult_pipe_if.sv
// Operand/result handshake bundle for the pipelined floating-point multiplier.
// The master drives operands and consumes results; the slave is the multiplier.
interface fpu_mult_pipe_if #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         rnd_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [3:0]   flags;

    modport master (
        output in_valid, a, b, rnd_mode, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, a, b, rnd_mode, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/fpu_mult_pipe.sv
// 3-stage floating-point multiplier: decode/multiply, normalise, round/pack.
// Subnormals are flushed on input and output; one global advance stalls every stage.
module fpu_mult_pipe #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic           clk,
    input  logic           rst,
    fpu_mult_pipe_if.slave bus
);
    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int PW     = 2 * MAN_W + 2;
    localparam int EW     = EXP_W + 2;
    localparam int BIAS   = (1 << (EXP_W - 1)) - 1;
    localparam int EMAX   = (1 << EXP_W) - 1;
    localparam int STAGES = 3;

    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef struct packed {
        logic          sign;
        logic [EW-1:0] exp;
        logic [PW-1:0] prod;
        logic          rnd;
        logic          spec;
        logic [W-1:0]  spec_res;
        logic [3:0]    spec_flags;
    } s1_t;

    typedef struct packed {
        logic             sign;
        logic [EW-1:0]    exp;
        logic [MAN_W-1:0] mant;
        logic             guard;
        logic             sticky;
        logic             rnd;
        logic             spec;
        logic [W-1:0]     spec_res;
        logic [3:0]       spec_flags;
    } s2_t;

    logic [STAGES:1] vld_pipe;
    logic            adv;
    s1_t             s1_d, s1_q;
    s2_t             s2_d, s2_q;
    logic [W-1:0]    res_d, res_q;
    logic [3:0]      flags_d, flags_q;

    assign adv           = !vld_pipe[STAGES] || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = vld_pipe[STAGES];
    assign bus.result    = res_q;
    assign bus.flags     = flags_q;

    // S1: classify and multiply
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, snan;

    assign {sa, ea, ma} = bus.a;
    assign {sb, eb, mb} = bus.b;
    assign a_nan  = (&ea) && (|ma);
    assign b_nan  = (&eb) && (|mb);
    assign a_inf  = (&ea) && !(|ma);
    assign b_inf  = (&eb) && !(|mb);
    assign a_zero = !(|ea);
    assign b_zero = !(|eb);
    assign snan   = (a_nan && !ma[MAN_W-1]) || (b_nan && !mb[MAN_W-1]);

    always_comb begin
        s1_d            = '0;
        s1_d.sign       = sa ^ sb;
        s1_d.exp        = EW'(ea) + EW'(eb) - EW'(BIAS);
        s1_d.prod       = PW'({1'b1, ma}) * PW'({1'b1, mb});
        s1_d.rnd        = bus.rnd_mode;
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
            s1_d.spec       = 1'b1;
            s1_d.spec_res   = QNAN;
            s1_d.spec_flags = {(a_inf && b_zero) || (a_zero && b_inf) || snan, 3'b000};
        end else if (a_inf || b_inf) begin
            s1_d.spec     = 1'b1;
            s1_d.spec_res = {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (a_zero || b_zero) begin
            s1_d.spec     = 1'b1;
            s1_d.spec_res = {sa ^ sb, {(W-1){1'b0}}};
        end
    end

    // S2: normalise so the leading one sits just above the mantissa field
    logic [PW-2:0] norm;

    always_comb begin
        norm            = s1_q.prod[PW-1] ? s1_q.prod[PW-2:0] : {s1_q.prod[PW-3:0], 1'b0};
        s2_d            = '0;
        s2_d.sign       = s1_q.sign;
        s2_d.exp        = s1_q.exp + EW'(s1_q.prod[PW-1]);
        s2_d.mant       = norm[PW-2 -: MAN_W];
        s2_d.guard      = norm[MAN_W];
        s2_d.sticky     = |norm[MAN_W-1:0];
        s2_d.rnd        = s1_q.rnd;
        s2_d.spec       = s1_q.spec;
        s2_d.spec_res   = s1_q.spec_res;
        s2_d.spec_flags = s1_q.spec_flags;
    end

    // S3: round, then range-check the (possibly carried) exponent
    logic          inc, inexact;
    logic [MAN_W:0] mant_r;
    logic [EW-1:0] exp_r;

    always_comb begin
        inc     = !s2_q.rnd && s2_q.guard && (s2_q.sticky || s2_q.mant[0]);
        inexact = s2_q.guard || s2_q.sticky;
        mant_r  = {1'b0, s2_q.mant} + (MAN_W+1)'(inc);
        exp_r   = s2_q.exp + EW'(mant_r[MAN_W]);
        res_d   = {s2_q.sign, exp_r[EXP_W-1:0], mant_r[MAN_W-1:0]};
        flags_d = {3'b000, inexact};
        if (s2_q.spec) begin
            res_d   = s2_q.spec_res;
            flags_d = s2_q.spec_flags;
        end else if (!exp_r[EW-1] && exp_r >= EW'(EMAX)) begin
            flags_d = 4'b0101;
            res_d   = s2_q.rnd ? {s2_q.sign, EXP_W'(EMAX - 1), {MAN_W{1'b1}}}
                               : {s2_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (exp_r[EW-1] || exp_r == '0) begin
            flags_d = 4'b0011;
            res_d   = {s2_q.sign, {(W-1){1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            res_q    <= '0;
            flags_q  <= '0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], bus.in_valid};
            if (vld_pipe[STAGES-1]) begin
                res_q   <= res_d;
                flags_q <= flags_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end
endmodule

// File: tb/tb_fpu_mult_pipe.sv
// Directed bench for fpu_mult_pipe (FP16): arithmetic vectors, latency,
// backpressure ordering and mid-flight reset.
module tb_fpu_mult_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fpu_mult_pipe_if #(.EXP_W(5), .MAN_W(10)) bus ();
    fpu_mult_pipe #(.EXP_W(5), .MAN_W(10)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk = 0;
    int n_err = 0;

    localparam int NV = 16;
    localparam logic [15:0] VA [NV] = '{16'h3E00, 16'hBC00, 16'h3C01, 16'h3C01, 16'h3C01, 16'h7BFF,
                                        16'h7BFF, 16'h0400, 16'h8400, 16'h7C00, 16'hFC00, 16'h7D00,
                                        16'h7E00, 16'h0001, 16'h3C01, 16'h3C01};
    localparam logic [15:0] VB [NV] = '{16'h4000, 16'h4000, 16'h3C01, 16'h3BFF, 16'h3BFF, 16'h4000,
                                        16'h4000, 16'h3800, 16'h3800, 16'h0000, 16'h4000, 16'h3C00,
                                        16'h3C00, 16'h3C00, 16'h3E00, 16'h3E00};
    localparam logic        VR [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                                        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic [15:0] VE [NV] = '{16'h4200, 16'hC000, 16'h3C02, 16'h3C00, 16'h3C00, 16'h7C00,
                                        16'h7BFF, 16'h0000, 16'h8000, 16'h7E00, 16'hFC00, 16'h7E00,
                                        16'h7E00, 16'h0000, 16'h3E02, 16'h3E01};
    localparam logic [3:0]  VF [NV] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h5, 4'h5, 4'h3,
                                        4'h3, 4'h8, 4'h0, 4'h8, 4'h0, 4'h0, 4'h1, 4'h1};

    int          idx, nout, seen;
    logic        acc;
    logic [15:0] outs [6];

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input int i);
        bus.a        = VA[i];
        bus.b        = VB[i];
        bus.rnd_mode = VR[i];
    endtask

    // one isolated op: latency, result and flags
    task automatic run_op(input int i);
        int lat;
        drive(i);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("lat[%0d]", i), 16'(lat), 16'd3);
        chk($sformatf("res[%0d]", i), bus.result, VE[i]);
        chk($sformatf("flg[%0d]", i), 16'(bus.flags), 16'(VF[i]));
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.rnd_mode = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_out_valid", 16'(bus.out_valid), 16'd0);
        chk("rst_result", bus.result, 16'h0000);
        chk("rst_flags", 16'(bus.flags), 16'd0);
        chk("rst_in_ready", 16'(bus.in_ready), 16'd1);

        for (int i = 0; i < NV; i++) run_op(i);

        // backpressure: consumer stalls while six ops are offered
        bus.out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            drive(idx);
            bus.in_valid = 1'b1;
            #1 acc = bus.in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            if (c >= 2) begin
                chk($sformatf("bp_hold_v%0d", c), 16'(bus.out_valid), 16'd1);
                chk($sformatf("bp_hold_r%0d", c), bus.result, VE[0]);
            end
        end
        chk("bp_accepted", 16'(idx), 16'd3);
        chk("bp_in_ready", 16'(bus.in_ready), 16'd0);

        bus.out_ready = 1'b1;
        nout = 0;
        for (int c = 0; c < 40 && nout < 6; c++) begin
            bus.in_valid = (idx < 6);
            if (idx < 6) drive(idx);
            #1;
            acc = bus.in_valid && bus.in_ready;
            if (bus.out_valid) begin
                if (nout < 6) outs[nout] = bus.result;
                nout++;
            end
            @(posedge clk); #1;
            if (acc) idx++;
        end
        bus.in_valid = 1'b0;
        chk("bp_count", 16'(nout), 16'd6);
        for (int k = 0; k < 6; k++) chk($sformatf("bp_order[%0d]", k), outs[k], VE[k]);
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (bus.out_valid) seen++;
            @(posedge clk); #1;
        end
        chk("bp_no_extra", 16'(seen), 16'd0);

        // reset with two ops in flight
        for (int k = 0; k < 2; k++) begin
            drive(k);
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            if (bus.out_valid) seen++;
            @(posedge clk); #1;
        end
        chk("mid_rst_no_out", 16'(seen), 16'd0);
        chk("mid_rst_in_ready", 16'(bus.in_ready), 16'd1);
        chk("mid_rst_result", bus.result, 16'h0000);
        run_op(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
